// File: rtl/pending_priority_encoder.sv
// Sticky pending-event register with a registered valid/ready output presenting
// the highest-priority unmasked pending index; a parametrised 8-to-3 encoder successor.
module pending_priority_encoder #(
    parameter int N            = 8,
    parameter int IDX_W        = 3,
    parameter int PRIORITY_MSB = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic [IDX_W:0]   pending_cnt,
    output logic             overflow
);

    if (N < 2 || N > 64 || IDX_W != $clog2(N)) begin : g_param_check
        $error("pending_priority_encoder: N must be 2..64 and IDX_W must equal clog2(N)");
    end

    logic             accept;
    logic [N-1:0]     clr;
    logic [N-1:0]     set;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     cand;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cnt_next;
    logic             overflow_next;

    assign accept        = out_valid && out_ready;
    assign clr           = accept ? (N'(1) << out_idx) : '0;
    assign set           = enable ? req : '0;
    // A bit cleared and re-requested in the same cycle stays pending.
    assign pending_next  = (pending & ~clr) | set;
    assign cand          = pending_next & ~mask;
    assign overflow_next = |(set & pending & ~clr);

    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        pick = '0;
        for (int i = 0; i < N; i++) begin
            if (PRIORITY_MSB != 0) begin
                if (cand[i]) pick = IDX_W'(i);
            end else if (cand[N-1-i]) begin
                pick = IDX_W'(N-1-i);
            end
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + (IDX_W+1)'(pending_next[i]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
        end else begin
            pending     <= pending_next;
            pending_cnt <= cnt_next;
            overflow    <= overflow_next;
            // No preemption: a stalled presentation holds until accepted.
            if (!out_valid || accept) begin
                out_valid <= |cand;
                out_idx   <= pick;
            end
        end
    end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Self-checking bench: MSB-priority and LSB-priority instances share stimulus and are
// compared every cycle against a behavioural event-queue model, plus directed expectations.
module tb_pending_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic [7:0] mask;
    logic       out_ready;

    logic       v0, v1, ov0, ov1;
    logic [2:0] idx0, idx1;
    logic [7:0] pend0, pend1;
    logic [3:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    // Reference state per instance: 0 = highest index wins, 1 = lowest index wins
    logic [7:0] m_pend  [2];
    logic       m_valid [2];
    logic [2:0] m_idx   [2];
    logic       m_ovf   [2];
    logic [3:0] m_cnt   [2];

    always #5 clk = ~clk;

    pending_priority_encoder #(.N(8), .IDX_W(3), .PRIORITY_MSB(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .mask(mask),
        .out_valid(v0), .out_ready(out_ready), .out_idx(idx0),
        .pending(pend0), .pending_cnt(cnt0), .overflow(ov0)
    );

    pending_priority_encoder #(.N(8), .IDX_W(3), .PRIORITY_MSB(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .mask(mask),
        .out_valid(v1), .out_ready(out_ready), .out_idx(idx1),
        .pending(pend1), .pending_cnt(cnt1), .overflow(ov1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] best(input logic [7:0] c, input bit msb_first);
        if (msb_first) begin
            for (int i = 7; i >= 0; i--) if (c[i]) return 3'(i);
        end else begin
            for (int i = 0; i < 8; i++) if (c[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = '0; m_valid[p] = 0; m_idx[p] = '0; m_ovf[p] = 0; m_cnt[p] = '0;
        end
    endtask

    task automatic check_all();
        check("msb.valid",   64'(v0),    64'(m_valid[0]));
        check("msb.idx",     64'(idx0),  64'(m_idx[0]));
        check("msb.pending", 64'(pend0), 64'(m_pend[0]));
        check("msb.cnt",     64'(cnt0),  64'(m_cnt[0]));
        check("msb.ovf",     64'(ov0),   64'(m_ovf[0]));
        check("lsb.valid",   64'(v1),    64'(m_valid[1]));
        check("lsb.idx",     64'(idx1),  64'(m_idx[1]));
        check("lsb.pending", 64'(pend1), 64'(m_pend[1]));
        check("lsb.cnt",     64'(cnt1),  64'(m_cnt[1]));
        check("lsb.ovf",     64'(ov1),   64'(m_ovf[1]));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic [7:0] r, input logic en, input logic [7:0] mk, input logic rdy);
        logic       acc;
        logic [7:0] nxt;
        req = r; enable = en; mask = mk; out_ready = rdy;
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            acc = m_valid[p] && rdy;
            nxt = m_pend[p];
            if (acc) nxt[m_idx[p]] = 1'b0;
            m_ovf[p] = en && ((r & nxt) != 0);
            if (en) nxt = nxt | r;
            m_pend[p] = nxt;
            m_cnt[p]  = 4'($countones(nxt));
            if (!m_valid[p] || acc) begin
                m_valid[p] = ((nxt & ~mk) != 0);
                m_idx[p]   = best(nxt & ~mk, p == 0);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; enable = 1'b1; req = 8'hFF; mask = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid",   64'(v0),    64'd0);
        check("rst.pending", 64'(pend0), 64'd0);
        check("rst.idx",     64'(idx0),  64'd0);
        check("rst.cnt",     64'(cnt0),  64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // All lines at once
        cycle(8'hFF, 1, 8'h00, 0);
        check("all.valid", 64'(v0),   64'd1);
        check("all.idx",   64'(idx0), 64'd7);
        check("all.cnt",   64'(cnt0), 64'd8);
        for (int i = 0; i < 8; i++) cycle(8'h00, 1, 8'h00, 1);
        check("drain.valid", 64'(v0), 64'd0);

        // Walking single requests with continuous accept
        for (int i = 0; i < 8; i++) begin
            cycle(8'(1 << i), 1, 8'h00, 1);
            check($sformatf("walk%0d.idx", i), 64'(idx0), 64'(i));
            check($sformatf("walk%0d.ovf", i), 64'(ov0), 64'd0);
        end
        cycle(8'h00, 1, 8'h00, 1);
        check("walk.empty", 64'(pend0), 64'd0);

        // Stall, no preemption, then back-to-back accepts
        cycle(8'h24, 1, 8'h00, 0);
        check("stall.idx0", 64'(idx0), 64'd5);
        cycle(8'h00, 1, 8'h00, 0);
        cycle(8'h00, 1, 8'h00, 0);
        cycle(8'h80, 1, 8'h00, 0);
        check("stall.nopreempt", 64'(idx0), 64'd5);
        cycle(8'h00, 1, 8'h00, 1);
        check("b2b.idx7", 64'(idx0), 64'd7);
        cycle(8'h00, 1, 8'h00, 1);
        check("b2b.idx2", 64'(idx0), 64'd2);
        cycle(8'h00, 1, 8'h00, 1);
        check("b2b.empty", 64'(v0), 64'd0);

        // Masking on the lowest-index-wins instance
        cycle(8'h90, 1, 8'h10, 0);
        check("mask.lsb.idx", 64'(idx1), 64'd7);
        cycle(8'h00, 1, 8'h10, 1);
        check("mask.lsb.valid", 64'(v1),    64'd0);
        check("mask.lsb.pend",  64'(pend1), 64'h10);
        cycle(8'h00, 1, 8'h00, 0);
        check("unmask.lsb.idx", 64'(idx1), 64'd4);
        cycle(8'h00, 1, 8'h00, 1);

        // Overflow and same-cycle accept/re-request
        cycle(8'h08, 1, 8'h00, 0);
        cycle(8'h08, 1, 8'h00, 0);
        check("ovf.pulse", 64'(ov0),  64'd1);
        check("ovf.cnt",   64'(cnt0), 64'd1);
        cycle(8'h00, 1, 8'h00, 0);
        check("ovf.gone", 64'(ov0), 64'd0);
        cycle(8'h08, 1, 8'h00, 1);
        check("repend.ovf",  64'(ov0),   64'd0);
        check("repend.pend", 64'(pend0), 64'h08);
        check("repend.idx",  64'(idx0),  64'd3);

        // enable=0 ignores requests, then asynchronous reset mid-stall
        cycle(8'hFF, 0, 8'h00, 0);
        check("en0.pend", 64'(pend0), 64'h08);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.valid", 64'(v0),    64'd0);
        check("arst.pend",  64'(pend0), 64'd0);
        check("arst.cnt",   64'(cnt1),  64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(8'($urandom & $urandom & $urandom), ($urandom_range(0, 7) != 0),
                  8'($urandom & $urandom & $urandom), ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/pending_priority_encoder.md
Name: pending_priority_encoder

Overview:
Parametrised, registered successor to the team's 8-to-3 encoder. Single-cycle request pulses on N lines are captured into a sticky pending register. The highest-priority unmasked pending index is presented on a valid/ready output port and cleared when the consumer accepts it. It sits between event sources (timers, peripherals) and a sequencer or CPU-side consumer, as a small interrupt-style event queue.

Parameters:
N, 8, number of request lines (2..64)
IDX_W, 3, width of out_idx; must equal clog2(N); elaboration error otherwise
PRIORITY_MSB, 1, 1 = highest index wins; 0 = index 0 wins

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = capture req this cycle; 0 = req ignored
req  input  N  request lines, one bit per source, sampled each edge
mask  input  N  1 = source excluded from selection (still captured)
out_valid  output  1  out_idx holds a pending event
out_ready  input  1  consumer accepts when out_valid && out_ready
out_idx  output  IDX_W  index of presented event
pending  output  N  registered pending vector
pending_cnt  output  IDX_W+1  popcount of pending, registered
overflow  output  1  one-cycle pulse: request hit an already-pending bit

Behaviour:
- Reset (async assert, sync-safe deassert by upstream): pending=0, pending_cnt=0, out_valid=0, out_idx=0, overflow=0.
- accept = out_valid && out_ready. clr = one-hot(out_idx) when accept, else 0.
- set = req when enable=1, else 0.
- pending_next = (pending & ~clr) | set. Set wins when a bit is cleared and set in the same cycle; that bit re-pends.
- cand = pending_next & ~mask. The pick function returns the highest set index (PRIORITY_MSB=1) or the lowest set index (PRIORITY_MSB=0).
- Output register, evaluated each edge:
  - If out_valid=0 or accept: out_valid <= |cand; out_idx <= pick(cand), or 0 when cand=0.
  - Otherwise (stalled): out_valid and out_idx hold.
- Latency: a req sampled at edge k with the output idle gives out_valid=1 and the correct out_idx after edge k (1 cycle). Back-to-back accepts deliver one event per cycle with no bubble.
- No preemption: while stalled, a newly arriving higher-priority request does not change out_idx. Masking the presented bit while stalled does not retract it.
- The presented bit stays set in pending until accepted.
- mask changes take effect at the next selection only.
- overflow <= |(set & pending & ~clr), a 1-cycle pulse. The pending bit is unchanged (stays 1).
- pending_cnt <= popcount(pending_next). It ranges 0..N, and N fits in IDX_W+1 bits.
- enable=0: nothing is captured, but presentation and accept continue normally.
- All pending bits masked: out_valid drops after the current event is accepted. Events stay pending and present after an unmask, 1 cycle later.
- Reset mid-transaction: all state clears immediately. The consumer must discard any in-flight event.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset with req=8'hFF held → out_valid=0, pending=0, out_idx=0, pending_cnt=0. After rst_n rises, enable=1, req=8'hFF for 1 cycle → next cycle out_valid=1, out_idx=7, pending_cnt=8.
- Walk req=1<<i, i=0..7, one per cycle, out_ready=1, enable=1 → out_idx=i one cycle after each pulse; pending returns to 0 after each accept; overflow stays 0.
- req=8'b0010_0100, out_ready=0 for 3 cycles, then req=8'h80 pulse → out_idx stays 5 throughout the stall. Then out_ready=1 → accepts 5, 7, 2 on consecutive cycles; out_valid falls after 2.
- PRIORITY_MSB=0, req=8'b1001_0000, mask=8'b0001_0000 → out_idx=7. After accept, out_valid=0 and pending=8'h10. Clear mask → out_idx=4 next cycle.
- pending=8'h08 presented and stalled, req=8'h08 again → overflow=1 for exactly 1 cycle, pending_cnt stays 1. Accept and re-request bit 3 in the same cycle → overflow=0, bit 3 re-pends, out_idx=3 next cycle.
- enable=0 with req=8'hFF → pending unchanged. Assert rst_n=0 mid-stall between edges → all outputs go to 0 immediately, without waiting for a clock edge.
